// File: rtl/fsm_lights_pkg.sv
// ---------------------------------------------------------------------------
// fsm_lights_pkg
// Shared definitions for the push-button front end of the light sequencer:
//   - debounce state encoding (2 bits)
//   - default debounce / auto-repeat periods
//   - helper mapping a debounce state to its debounced level
// ---------------------------------------------------------------------------
package fsm_lights_pkg;

    // 10 ms and 500 ms at a 100 MHz system clock.
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_CYCLES_DEF   = 50_000_000;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_e;

    // The button counts as pressed once accepted, until a release is accepted.
    function automatic logic db_level(input db_state_e s);
        logic lvl;
        case (s)
            DB_HELD:         lvl = 1'b1;
            DB_RELEASE_WAIT: lvl = 1'b1;
            DB_IDLE:         lvl = 1'b0;
            DB_PRESS_WAIT:   lvl = 1'b0;
            default:         lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One push-button channel: 2-flop synchroniser, four-state debounce FSM with
// a saturating stability counter, and a one-cycle press request.
// Optional auto-repeat while held is built only when BTN_REPEAT_EN is defined.
// Ports:
//   clk_i   system clock (rising edge)
//   rst_i   synchronous active-high reset
//   raw_i   asynchronous button input, high = pressed
//   level_o debounced level, registered
//   req_o   one-cycle press request, registered
// ---------------------------------------------------------------------------
module btn_debounce
    import fsm_lights_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic req_o
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic             sync1_q;
    logic             sync_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_req_s;
    logic             req_d, req_q;
    logic             level_q;

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            level_q <= db_level(state_q);
        end
    end

    // Debounce next state; the counter only runs in the two wait states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        press_req_s = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (sync_q) begin
                    state_d = DB_PRESS_WAIT;
                end else begin
                    state_d = DB_IDLE;
                end
            end
            DB_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = DB_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = DB_HELD;
                    press_req_s = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            DB_HELD: begin
                if (!sync_q) begin
                    state_d = DB_RELEASE_WAIT;
                end else begin
                    state_d = DB_HELD;
                end
            end
            DB_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = DB_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = DB_IDLE;
            end
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_q, rep_d;
    logic             rep_req_s;

    // Repeat period counter; runs only while staying in HELD.
    always_comb begin
        rep_d     = '0;
        rep_req_s = 1'b0;
        if ((state_q == DB_HELD) && sync_q) begin
            if (rep_q == REP_LAST) begin
                rep_req_s = 1'b1;
            end else begin
                rep_d = sat_inc(rep_q);
            end
        end else begin
            rep_d = '0;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign req_d = press_req_s | rep_req_s;
`else
    assign req_d = press_req_s;
`endif

    assign level_o = level_q;
    assign req_o   = req_q;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Synchronises and debounces two push-buttons and turns each accepted press
// into a single-cycle pulse. Coincident requests are serialised: A goes out
// first, B follows one cycle later from a pending flag, so a and b are never
// high together. Auto-repeat while held is enabled by defining BTN_REPEAT_EN.
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous active-high reset
//   btn_a_raw  asynchronous button A, high = pressed
//   btn_b_raw  asynchronous button B, high = pressed
//   a, b       one-cycle press pulses, registered
//   a_level    debounced level of A, registered
//   b_level    debounced level of B, registered
// ---------------------------------------------------------------------------
module btn_conditioner
    import fsm_lights_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic a,
    output logic b,
    output logic a_level,
    output logic b_level
);

    logic req_a_s, req_b_s;
    logic a_q, a_d;
    logic b_q, b_d;
    logic pend_q, pend_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .raw_i   (btn_a_raw),
        .level_o (a_level),
        .req_o   (req_a_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .raw_i   (btn_b_raw),
        .level_o (b_level),
        .req_o   (req_b_s)
    );

    // Arbitration: A always wins; any B (new or pending) waits while A fires,
    // and a second B request arriving while one is pending merges into it.
    always_comb begin
        a_d    = req_a_s;
        b_d    = 1'b0;
        pend_d = 1'b0;
        if (req_a_s) begin
            pend_d = req_b_s | pend_q;
        end else begin
            b_d = req_b_s | pend_q;
        end
    end

    // Output pulse and pending-B registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            pend_q <= pend_d;
        end
    end

    assign a = a_q;
    assign b = b_q;

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end stage between the two raw push-buttons and the light-sequencing state machine. It synchronises each button, debounces it, and converts every accepted press into a single-cycle pulse on `a` or `b`. The downstream FSM advances once per pulse, and never on a held level. Coincident presses are serialised so that no press is lost and the downstream never sees `a` and `b` high together.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `REPEAT_CYCLES`, default 50_000_000: auto-repeat period while held; used only when `BTN_REPEAT_EN` is defined; legal range ≥ 2.
- `clk`  input  1  single system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `btn_a_raw`  input  1  asynchronous button A, high = pressed.
- `btn_b_raw`  input  1  asynchronous button B, high = pressed.
- `a`  output  1  one-cycle press pulse for A; registered.
- `b`  output  1  one-cycle press pulse for B; registered.
- `a_level`  output  1  debounced level of A; registered.
- `b_level`  output  1  debounced level of B; registered.

## Operation
- Each raw input passes through a 2-flop synchroniser to give `sync`.
- Per-button debounce FSM with states `IDLE` (level 0), `PRESS_WAIT`, `HELD` (level 1) and `RELEASE_WAIT`:
  - `IDLE` → `PRESS_WAIT` when `sync` = 1.
  - `PRESS_WAIT` → `HELD` after `DEBOUNCE_CYCLES` consecutive cycles of `sync` = 1. Any cycle with `sync` = 0 returns it to `IDLE` and clears the counter.
  - `HELD` → `RELEASE_WAIT` when `sync` = 0.
  - `RELEASE_WAIT` → `IDLE` after `DEBOUNCE_CYCLES` consecutive cycles of `sync` = 0. Any cycle with `sync` = 1 returns it to `HELD`.
- A press request is raised on the `PRESS_WAIT` → `HELD` transition only. Releases raise nothing.
- Counter width is `$clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1`. The counter saturates and never wraps.
- Arbitration of the two request streams:
  - Request A alone → `a` = 1 for the next cycle.
  - Request B alone → `b` = 1 for the next cycle.
  - A and B in the same cycle → `a` first, then `b` in the following cycle via a 1-bit pending register.
  - A new B request while B is already pending is merged. This cannot occur with `DEBOUNCE_CYCLES` ≥ 2.
- `a` and `b` are never high in the same cycle. Each is never high for 2 consecutive cycles from a single press.
- `a_level` and `b_level` are 1 exactly in states `HELD` and `RELEASE_WAIT`.

## Timing
- Reset values: `a` = 0, `b` = 0, `a_level` = 0, `b_level` = 0. Both FSMs in `IDLE`, counters 0, synchronisers 0, pending B cleared.
- Latency: if `btn_*_raw` is first sampled high at edge k and stays high, `a`/`b` is high in the cycle following edge k + `DEBOUNCE_CYCLES` + 3. The same edge raises `*_level`.
- Release latency to `*_level` falling is identical.
- A deferred `b` from a coincident press comes exactly 1 cycle later than the formula above.
- Reset mid-count aborts the count with no pulse.
- A button still held when reset deasserts is debounced afresh and produces one pulse after the normal latency.
- Reset asserted in the cycle a pulse would appear wins: the output is 0 and any pending B is dropped.

## Configuration
- `BTN_REPEAT_EN` defined: while in `HELD`, a further press request is raised every `REPEAT_CYCLES` cycles after the initial pulse.
  - The repeat counter clears on leaving `HELD`.
  - Repeat requests go through the same arbitration as initial presses.
- `BTN_REPEAT_EN` undefined: exactly one pulse per accepted press, and the repeat logic is absent.

## Structure
- Shared package `fsm_lights_pkg` holds:
  - the debounce state encoding (`DB_IDLE`, `DB_PRESS_WAIT`, `DB_HELD`, `DB_RELEASE_WAIT`, 2 bits);
  - the default `DEBOUNCE_CYCLES` and `REPEAT_CYCLES` constants.
- Sub-module `btn_debounce`, instantiated twice, contains the synchroniser, debounce FSM, counter, optional repeat logic, `level` output and one-cycle `req` output.
- The top level contains only the arbitration and pending-B register, and registers `a`/`b`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `REPEAT_CYCLES` = 10.
- Clean press and release: `btn_a_raw` rises at edge 10 and is held 20 cycles → `a` high for exactly the cycle after edge 17. `a_level` is 1 from the same cycle until 7 edges after release. `b` stays 0.
- Bounce: `btn_b_raw` toggles 1,0,1,0 on successive cycles, then holds 1 → the counter restarts on each toggle. Exactly one `b` pulse, 7 edges after the final rise.
- Glitch: `btn_a_raw` high for 3 cycles only → no `a` pulse and `a_level` stays 0.
- Coincident: both raw inputs rise at edge 10 → `a` in the cycle after edge 17 and `b` in the cycle after edge 18. They are never high together.
- Reset: `rst` asserted at edge 15 during an A press-wait and released at edge 16, button held → no pulse before edge 23, then one `a` pulse after edge 23. All outputs read 0 during reset.
- `BTN_REPEAT_EN` defined, A held 40 cycles → pulses after edges 17, 27, 37. With the macro undefined → a single pulse after edge 17.
